// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// word geometry and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFS_W      = $clog2(WORD_BYTES);

    localparam int P0 = 0;
    localparam int P1 = 1;

    function automatic logic misaligned(input logic [OFS_W-1:0] lsb);
        return lsb != '0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. last_grant only moves when both ports
// contend, so a lone requester never steals the other's next turn.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (&req)) begin
            last_grant <= gnt[P1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory between two requesters: round-robin
// grant, one-cycle strobe, one-cycle acknowledge with read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_dout
);

    state_t        state;
    logic          port_q;
    logic          we_q;
    logic [1:0]    gnt;
    logic          advance;
    logic          gport;
    logic          gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gwdata;

    assign advance = (state == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1, req0}),
        .advance (advance),
        .gnt     (gnt)
    );

    assign gport  = gnt[P1];
    assign gwe    = gport ? we1    : we0;
    assign gaddr  = gport ? addr1  : addr0;
    assign gwdata = gport ? wdata1 : wdata0;

    // mem_addr/mem_din double as the grant-time latch, so later requester
    // changes cannot reach the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        port_q <= gport;
                        if (misaligned(gaddr[OFS_W-1:0])) begin
                            rdata <= '0;
                            state <= RESP;
                            if (gport) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            we_q      <= gwe;
                            mem_addr  <= gaddr;
                            mem_din   <= gwdata;
                            mem_write <= gwe;
                            mem_read  <= !gwe;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    rdata     <= we_q ? '0 : mem_dout;
                    if (port_q) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand-written
// contention, busy-hold, reset and latching sequences, with a scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, err0, ack1, err1, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
    );

    // Memory model: unwritten words hold 0xA5A5_00<index>
    logic [31:0] mem [0:63];
    bit inited = 1'b0;
    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | i;
            inited <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr[7:2]];

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input logic e, input logic [31:0] rd);
        exp_t x;
        x.port = p;
        x.err  = e;
        x.rd   = rd;
        sb.push_back(x);
    endtask

    task automatic set_port(input int p, input logic rq, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = rq; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic take_ack(input string name, output int p);
        exp_t e;
        p = ack1 ? 1 : 0;
        check({name, "_ack_excl"}, {31'b0, ack0 & ack1}, 32'd0);
        check({name, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_port"}, p, e.port);
            check({name, "_err"}, {31'b0, (p == 1) ? err1 : err0}, {31'b0, e.err});
            check({name, "_rdata"}, rdata, e.rd);
        end
    endtask

    task automatic run_one(input vec_t v, input bit chg, input string name);
        int edges = 0;
        int wc = 0;
        int rc = 0;
        int p;
        bit got = 1'b0;
        push_exp(v.port, v.err, v.rd);
        set_port(v.port, 1'b1, v.we, v.addr, v.wd);
        while (!got && edges < 20) begin
            @(posedge clk); edges++;
            @(negedge clk);
            wc += int'(mem_write);
            rc += int'(mem_read);
            if (chg && edges == 1) begin
                set_port(v.port, 1'b1, v.we, 32'd40, v.wd);
                #1 check({name, "_addr_latched"}, mem_addr, v.addr);
            end
            if (ack0 || ack1) begin
                got = 1'b1;
                take_ack(name, p);
                check({name, "_latency"}, edges, v.err ? 1 : 2);
            end
        end
        set_port(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
        check({name, "_ack_seen"}, {31'b0, got}, 32'd1);
        check({name, "_wr_cycles"}, wc, (!v.err && v.we) ? 1 : 0);
        check({name, "_rd_cycles"}, rc, (!v.err && !v.we) ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Port 0 reads a0 from the start; port 1 raises its read of a1 at
    // edge s1 (0 = together). 'first' is the port expected to be acked first.
    task automatic dual(input logic [31:0] a0, input logic [31:0] a1, input int s1,
                        input int first, input logic [31:0] rd0, input logic [31:0] rd1,
                        input string name);
        int edges = 0;
        int extra = 0;
        int p;
        int ack_edge[2] = '{0, 0};
        bit done[2] = '{1'b0, 1'b0};
        if (first == 0) begin
            push_exp(0, 1'b0, rd0); push_exp(1, 1'b0, rd1);
        end else begin
            push_exp(1, 1'b0, rd1); push_exp(0, 1'b0, rd0);
        end
        set_port(0, 1'b1, 1'b0, a0, 32'd0);
        if (s1 == 0) set_port(1, 1'b1, 1'b0, a1, 32'd0);
        while (!(done[0] && done[1]) && edges < 30) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (s1 != 0 && edges == s1) set_port(1, 1'b1, 1'b0, a1, 32'd0);
            if (ack0 || ack1) begin
                take_ack(name, p);
                ack_edge[p] = edges;
                done[p] = 1'b1;
                set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check({name, "_both_acked"}, {30'b0, done[1], done[0]}, 32'd3);
        check({name, "_first_edge"}, ack_edge[first], 32'd2);
        check({name, "_second_edge"}, ack_edge[1 - first], 32'd5);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 || ack1) extra++;
        end
        check({name, "_no_dup"}, extra, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int extra;
        vt[0] = '{0, 1'b1, 32'd16, 32'h12345678, 1'b0, 32'h00000000};
        vt[1] = '{0, 1'b1, 32'd24, 32'h89abcdef, 1'b0, 32'h00000000};
        vt[2] = '{1, 1'b0, 32'd16, 32'h0,        1'b0, 32'h12345678};
        vt[3] = '{1, 1'b0, 32'd20, 32'h0,        1'b0, 32'hA5A50005};
        vt[4] = '{1, 1'b0, 32'd24, 32'h0,        1'b0, 32'h89abcdef};
        vt[5] = '{1, 1'b0, 32'd18, 32'h0,        1'b1, 32'h00000000};
        vt[6] = '{0, 1'b1, 32'd32, 32'h55aa55aa, 1'b0, 32'h00000000};
        vt[7] = '{0, 1'b0, 32'd3,  32'h0,        1'b1, 32'h00000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", {31'b0, ack0}, 32'd0);
        check("rst_ack1", {31'b0, ack1}, 32'd0);
        check("rst_err", {30'b0, err1, err0}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_one(vt[i], 1'b0, $sformatf("vec%0d", i));

        run_one('{0, 1'b0, 32'd16, 32'h0, 1'b0, 32'h12345678}, 1'b1, "latch");

        pulse_reset();
        dual(32'd16, 32'd16, 0, 0, 32'h12345678, 32'h12345678, "pair_a");
        dual(32'd16, 32'd16, 0, 1, 32'h12345678, 32'h12345678, "pair_b");

        dual(32'd24, 32'd20, 1, 0, 32'h89abcdef, 32'hA5A50005, "held");

        set_port(0, 1'b1, 1'b1, 32'd32, 32'hdeadbeef);
        @(posedge clk);
        @(negedge clk);
        check("midrst_write_on", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_write_off", {31'b0, mem_write}, 32'd0);
        check("midrst_addr_clr", mem_addr, 32'd0);
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 || ack1) extra++;
        end
        check("midrst_no_ack", extra, 32'd0);
        run_one('{0, 1'b0, 32'd32, 32'h0, 1'b0, 32'h55aa55aa}, 1'b0, "midrst_read");

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
